// File: rtl/deslocador_universal_prog.sv
`default_nettype none
// ============================================================================
// Module   : deslocador_universal_prog
// Purpose  : Universal shift/rotate register. It runs a programmable number of
//            one-bit steps under a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module deslocador_universal_prog #(
    parameter int size = 8,
    parameter int CW   = $clog2(size + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [CW-1:0]   N,
    input  logic [size-1:0] E,
    input  logic            Er,
    input  logic            El,
    output logic [size-1:0] Y,
    output logic            Sout,
    output logic            busy,
    output logic            done
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_SHIFT = 2'd1;
    localparam logic [1:0] c_DONE  = 2'd2;

    localparam logic [2:0] c_OP_LOAD = 3'b001;
    localparam logic [2:0] c_OP_SHL  = 3'b010;
    localparam logic [2:0] c_OP_SHR  = 3'b011;
    localparam logic [2:0] c_OP_ROTL = 3'b100;
    localparam logic [2:0] c_OP_ROTR = 3'b101;
    localparam logic [2:0] c_OP_ASR  = 3'b110;

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [2:0]      op_q, op_d;
    logic [size-1:0] y_q, y_d;
    logic            sout_q, sout_d;

    logic [size-1:0] w_step_y;
    logic            w_step_out;
    logic            w_is_shift_op;

    // One step of the latched operation; HOLD and reserved leave everything as is.
    always_comb begin
        w_step_y   = y_q;
        w_step_out = sout_q;
        case (op_q)
            c_OP_SHL: begin
                w_step_y   = {y_q[size-2:0], Er};
                w_step_out = y_q[size-1];
            end
            c_OP_SHR: begin
                w_step_y   = {El, y_q[size-1:1]};
                w_step_out = y_q[0];
            end
            c_OP_ROTL: begin
                w_step_y   = {y_q[size-2:0], y_q[size-1]};
                w_step_out = y_q[size-1];
            end
            c_OP_ROTR: begin
                w_step_y   = {y_q[0], y_q[size-1:1]};
                w_step_out = y_q[0];
            end
            c_OP_ASR: begin
                w_step_y   = {y_q[size-1], y_q[size-1:1]};
                w_step_out = y_q[0];
            end
            default: begin
                w_step_y   = y_q;
                w_step_out = sout_q;
            end
        endcase
    end

    assign w_is_shift_op = (op >= c_OP_SHL) && (op <= c_OP_ASR);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        y_d     = y_q;
        sout_d  = sout_q;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    op_d = op;
                    if (op == c_OP_LOAD) begin
                        y_d     = E;
                        state_d = c_DONE;
                    end else if (w_is_shift_op && (N != '0)) begin
                        count_d = N;
                        state_d = c_SHIFT;
                    end else begin
                        state_d = c_DONE;
                    end
                end
            end
            c_SHIFT: begin
                y_d     = w_step_y;
                sout_d  = w_step_out;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = c_DONE;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
            count_q <= '0;
            op_q    <= '0;
            y_q     <= '0;
            sout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            y_q     <= y_d;
            sout_q  <= sout_d;
        end
    end

    // Status flags decode straight from the state register, so they stay glitch-free.
    assign Y    = y_q;
    assign Sout = sout_q;
    assign busy = (state_q == c_SHIFT);
    assign done = (state_q == c_DONE);

endmodule
`default_nettype wire

// File: doc/deslocador_universal_prog.md
Name: deslocador_universal_prog

Overview:
Parametrised successor of the team's universal shift register. Adds rotate and arithmetic modes, a programmable shift count executed one bit per clock, and a start/busy/done handshake. A controller issues a command (op, N) and waits for done. Used wherever a multi-bit serial shift/rotate must run autonomously under a counter.

Parameters:
size, 8, register width in bits (>=2)
CW, $clog2(size+1), width of shift-count port N

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  command request; sampled only in IDLE
op  in  3  operation code, latched at accepted start
N  in  CW  number of single-bit shift steps, latched at accepted start
E  in  size  parallel load data (used by op LOAD)
Er  in  1  serial input entering the LSB on left shifts (sampled live every shift cycle)
El  in  1  serial input entering the MSB on logical right shifts (sampled live every shift cycle)
Y  out  size  register contents
Sout  out  1  last bit shifted or rotated out
busy  out  1  high while in SHIFT state
done  out  1  one-cycle pulse when a command completes

Behaviour:
- Reset (async, any state): Y=0, Sout=0, busy=0, done=0, count=0, state=IDLE. Reset mid-command aborts it; no done is produced.
- op codes: 000 HOLD; 001 LOAD; 010 SHL {Y[size-2:0],Er}, out=Y[size-1]; 011 SHR {El,Y[size-1:1]}, out=Y[0]; 100 ROTL {Y[size-2:0],Y[size-1]}, out=Y[size-1]; 101 ROTR {Y[0],Y[size-1:1]}, out=Y[0]; 110 ASR {Y[size-1],Y[size-1:1]}, out=Y[0]; 111 reserved, behaves as HOLD.
- FSM states: IDLE, SHIFT, DONE.
- IDLE: start=1 at edge -> latch op, N.
  - LOAD: Y<=E on the same edge -> DONE. N ignored.
  - HOLD/reserved, or shift op with N=0: Y unchanged -> DONE.
  - Shift op with N>0: count<=N -> SHIFT. Y unchanged on this edge.
- SHIFT: each edge performs one step of the latched op, Sout<=out bit, count<=count-1. Step with count==1 -> DONE.
- DONE: done=1 for exactly one cycle -> IDLE unconditionally.
- Latency: start edge at cycle t; a shift command with N>0 completes its last step at edge t+N; done is high during cycle t+N+1. Single-edge commands (LOAD/HOLD/N=0) assert done in cycle t+1.
- busy=1 exactly in SHIFT (N cycles). done and busy are never both high.
- start is ignored in SHIFT and DONE; no queueing. Back-to-back commands are therefore spaced by at least one IDLE cycle.
- op, N and E changes after acceptance have no effect. Er/El are read on every shift edge.
- N may exceed size. Steps continue cycle by cycle: SHL/SHR fill with serial inputs; rotates wrap modulo size; ASR saturates to all sign bits.
- Sout changes only on SHIFT steps; LOAD and HOLD leave it unchanged.
- Y is registered. No combinational path from inputs to any output.

Test Plan:
- size=4. rst pulse mid-simulation while idle -> Y=0000, Sout=0, busy=0, done=0 immediately, independent of clk.
- LOAD: E=1011, op=001, start for 1 cycle -> Y=1011 after 1 edge; done high 1 cycle; busy never high.
- SHL: Y=1011, op=010, N=2, Er=1 -> Y=0111 then 1111; busy high 2 cycles; Sout=0; done in cycle t+3.
- ROTR wrap: Y=1100, op=101, N=5 -> sequence 0110, 0011, 1001, 1100, 0110; final Y=0110, Sout=0; busy 5 cycles.
- ASR: Y=1000, op=110, N=3 -> 1100, 1110, 1111; Sout=0. Then SHR with N=0 -> done next cycle, Y stays 1111.
- Robustness:
  - start pulsed and op/E changed during SHIFT -> ignored; result unchanged.
  - rst asserted during SHIFT of an N=4 command -> Y=0, busy=0, no done pulse.
  - A new command is accepted afterwards normally.
